cuppa_trig_mc: RTL and testbench
================================

CUPPA_TRIG_MC -- requirements
Module: cuppa_trig_mc

Interface
REQ-001 SHALL have parameter N_CHAN, default 4: number of ADC channels compared against the threshold.
REQ-002 SHALL have parameter DATA_W, default 12: sample and threshold width.
REQ-003 SHALL have parameter HOLDOFF_W, default 16: holdoff counter width.
REQ-004 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port adc_data  input  N_CHAN*DATA_W: unsigned samples; channel k at bits [k*DATA_W +: DATA_W].
REQ-007 SHALL have port adc_valid  input  1: adc_data valid this cycle.
REQ-008 SHALL have port trig_et, trig_gt, trig_lt  input  1 each: threshold compare-mode enables (equal / greater / less).
REQ-009 SHALL have port trig_run  input  1: 1 = auto-rearm after holdoff; 0 = single-shot.
REQ-010 SHALL have port trig_thresh  input  DATA_W: threshold.
REQ-011 SHALL have port thresh_trig_en, ext_trig_en  input  1 each: source enables.
REQ-012 SHALL have port chan_mask  input  N_CHAN: 1 = channel participates.
REQ-013 SHALL have port holdoff  input  HOLDOFF_W: dead cycles after a trigger.
REQ-014 SHALL have port arm  input  1: single-cycle arm request.
REQ-015 SHALL have port ext_trig_in  input  1: asynchronous external trigger level.
REQ-016 SHALL have port count_clr  input  1: synchronous clear of trig_count.
REQ-017 SHALL have port trig_out  output  1: one-cycle trigger pulse.
REQ-018 SHALL have port trig_src  output  2: bit0 threshold, bit1 external; source(s) of last trigger.
REQ-019 SHALL have port trig_chan  output  N_CHAN: channels that hit on last trigger.
REQ-020 SHALL have port armed  output  1: high while state is ARMED.
REQ-021 SHALL have port trig_count  output  16: triggers issued; saturating.

Function
REQ-022 Per-channel condition: (trig_gt & s>th) | (trig_lt & s<th) | (trig_et & s==th), with chan_mask bit set; unsigned compare.
REQ-023 Per-channel prev-condition register SHALL update only on adc_valid=1; it SHALL be retained otherwise.
REQ-024 Channel hit: adc_valid=1 & condition=1 & prev=0 (rising crossing); threshold event = thresh_trig_en & OR of hits.
REQ-025 ext_trig_in SHALL pass a 2-flop synchronizer plus a 3rd flop; external event = ext_trig_en & s2 & ~s3.
REQ-026 States SHALL be IDLE, ARMED, HOLDOFF.
REQ-027 IDLE -> ARMED when arm=1 or trig_run=1.
REQ-028 ARMED, on any event: trig_out=1 on the next cycle; trig_src and trig_chan load; then HOLDOFF with counter = holdoff.
REQ-029 If holdoff=0, ARMED SHALL go directly to ARMED (trig_run=1) or IDLE (trig_run=0); the next event may fire one cycle later.
REQ-030 HOLDOFF SHALL decrement each cycle; at count 1 -> ARMED if trig_run=1, else IDLE. trig_run is sampled at exit.
REQ-031 Events in IDLE/HOLDOFF SHALL be discarded; edge/prev tracking continues in all states.
REQ-032 arm in ARMED or HOLDOFF SHALL be ignored.
REQ-033 Simultaneous threshold + external event -> one trig_out pulse, trig_src=2'b11.
REQ-034 Multi-channel hits -> trig_chan = bitmask of all hitting channels.
REQ-035 trig_src and trig_chan SHALL hold until the next trigger.
REQ-036 trig_count SHALL increment on each trig_out pulse and saturate at 0xFFFF.
REQ-037 count_clr SHALL clear trig_count; count_clr in the same cycle as a trig_out pulse SHALL give trig_count=0.
REQ-038 Both source enables 0, or all mode bits 0 with ext disabled -> trig_out never asserts.
REQ-039 Threshold latency: a crossing sample with adc_valid on cycle N -> trig_out high on cycle N+1.
REQ-040 External latency: ext_trig_in first sampled high at edge E -> trig_out high in the cycle after edge E+2.

Reset
REQ-041 rst=1 SHALL immediately force state IDLE; trig_out, trig_src, trig_chan, armed, trig_count, prev registers, sync flops and holdoff counter to 0.
REQ-042 rst mid-HOLDOFF or mid-synchronization SHALL abort with no trig_out; after release, state stays IDLE until arm or trig_run.

Verification
REQ-043 N_CHAN=4, th=0x800, gt=1, thresh_en=1, trig_run=0, holdoff=3, arm pulse; ch2 goes 0x7FF->0x801 -> one trig_out at N+1, trig_chan=4'b0100, trig_src=01, count=1, IDLE.
REQ-044 trig_run=1, holdoff=5; ch0 crosses at cycles 10 and 13, then again at 20 -> triggers at 11 and 21 only; the crossing at 13 is dropped in HOLDOFF.
REQ-045 ext_en=1, thresh_en=1; ext rise and ch1 crossing land on the same event cycle -> single pulse, trig_src=11, trig_chan=4'b0010.
REQ-046 lt=1, et=1, th=0x100; ch3 samples 0x200, 0x100 with adc_valid gaps -> fires on 0x100; chan_mask[3]=0 repeat -> no fire.
REQ-047 trig_count preset via 65535 triggers, one more -> stays 0xFFFF; count_clr -> 0.
REQ-048 rst asserted during HOLDOFF with ext_trig_in high -> outputs 0 at once; after release with arm=0 and trig_run=0 -> no trig_out.

Source files
------------

// File: rtl/cuppa_trig_mc.sv
// Multi-channel ADC threshold / external trigger controller with holdoff and
// single-shot or auto-rearm operation.
module cuppa_trig_mc #(
  parameter int unsigned N_CHAN    = 4,
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned HOLDOFF_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CHAN*DATA_W-1:0]   adc_data,
  input  logic                       adc_valid,
  input  logic                       trig_et,
  input  logic                       trig_gt,
  input  logic                       trig_lt,
  input  logic                       trig_run,
  input  logic [DATA_W-1:0]          trig_thresh,
  input  logic                       thresh_trig_en,
  input  logic                       ext_trig_en,
  input  logic [N_CHAN-1:0]          chan_mask,
  input  logic [HOLDOFF_W-1:0]       holdoff,
  input  logic                       arm,
  input  logic                       ext_trig_in,
  input  logic                       count_clr,
  output logic                       trig_out,
  output logic [1:0]                 trig_src,
  output logic [N_CHAN-1:0]          trig_chan,
  output logic                       armed,
  output logic [15:0]                trig_count
);

  typedef enum logic [1:0] {StIdle, StArmed, StHoldoff} state_e;

  state_e               state_q;
  logic [HOLDOFF_W-1:0] hold_cnt_q;
  logic [N_CHAN-1:0]    prev_q;
  logic [N_CHAN-1:0]    cond;
  logic [N_CHAN-1:0]    hit;
  logic                 ext_s1_q, ext_s2_q, ext_s3_q;
  logic                 thr_evt, ext_evt;
  logic                 trig_out_q;
  logic [1:0]           trig_src_q;
  logic [N_CHAN-1:0]    trig_chan_q;
  logic [15:0]          count_q;

  for (genvar k = 0; k < N_CHAN; k++) begin : g_chan
    logic [DATA_W-1:0] sample;
    assign sample  = adc_data[k*DATA_W +: DATA_W];
    assign cond[k] = chan_mask[k] & ((trig_gt & (sample > trig_thresh)) |
                                     (trig_lt & (sample < trig_thresh)) |
                                     (trig_et & (sample == trig_thresh)));
  end

  // Rising crossing only: condition true now, false on the previous valid sample.
  assign hit     = {N_CHAN{adc_valid}} & cond & ~prev_q;
  assign thr_evt = thresh_trig_en & (|hit);
  assign ext_evt = ext_trig_en & ext_s2_q & ~ext_s3_q;

  // Edge tracking runs in every state so a condition held through holdoff
  // does not re-fire on re-arm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= '0;
      ext_s1_q <= 1'b0;
      ext_s2_q <= 1'b0;
      ext_s3_q <= 1'b0;
    end else begin
      if (adc_valid) prev_q <= cond;
      ext_s1_q <= ext_trig_in;
      ext_s2_q <= ext_s1_q;
      ext_s3_q <= ext_s2_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      hold_cnt_q  <= '0;
      trig_out_q  <= 1'b0;
      trig_src_q  <= '0;
      trig_chan_q <= '0;
    end else begin
      trig_out_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (arm || trig_run) state_q <= StArmed;
        end
        StArmed: begin
          if (thr_evt || ext_evt) begin
            trig_out_q  <= 1'b1;
            trig_src_q  <= {ext_evt, thr_evt};
            trig_chan_q <= thr_evt ? hit : '0;
            if (holdoff == '0) begin
              state_q <= trig_run ? StArmed : StIdle;
            end else begin
              state_q    <= StHoldoff;
              hold_cnt_q <= holdoff;
            end
          end
        end
        StHoldoff: begin
          if (hold_cnt_q <= HOLDOFF_W'(1)) begin
            hold_cnt_q <= '0;
            state_q    <= trig_run ? StArmed : StIdle;
          end else begin
            hold_cnt_q <= hold_cnt_q - HOLDOFF_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Clear has priority so a clear coinciding with a pulse leaves zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (count_clr) begin
      count_q <= '0;
    end else if (trig_out_q && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign trig_out   = trig_out_q;
  assign trig_src   = trig_src_q;
  assign trig_chan  = trig_chan_q;
  assign armed      = (state_q == StArmed);
  assign trig_count = count_q;

endmodule

// File: tb/tb_cuppa_trig_mc.sv
// Scoreboard bench for cuppa_trig_mc: directed stimulus pushes expected pulses,
// a negedge monitor pops and compares source, channel mask and cycle.
module tb_cuppa_trig_mc;

  localparam int N_CHAN    = 4;
  localparam int DATA_W    = 12;
  localparam int HOLDOFF_W = 16;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [N_CHAN*DATA_W-1:0] adc_data;
  logic                     adc_valid = 1'b0;
  logic                     trig_et = 1'b0, trig_gt = 1'b0, trig_lt = 1'b0;
  logic                     trig_run = 1'b0;
  logic [DATA_W-1:0]        trig_thresh = '0;
  logic                     thresh_trig_en = 1'b0, ext_trig_en = 1'b0;
  logic [N_CHAN-1:0]        chan_mask = '0;
  logic [HOLDOFF_W-1:0]     holdoff = '0;
  logic                     arm = 1'b0, ext_trig_in = 1'b0, count_clr = 1'b0;
  logic                     trig_out;
  logic [1:0]               trig_src;
  logic [N_CHAN-1:0]        trig_chan;
  logic                     armed;
  logic [15:0]              trig_count;

  logic [DATA_W-1:0] samp [N_CHAN];
  for (genvar k = 0; k < N_CHAN; k++) begin : g_pack
    assign adc_data[k*DATA_W +: DATA_W] = samp[k];
  end

  cuppa_trig_mc #(.N_CHAN(N_CHAN), .DATA_W(DATA_W), .HOLDOFF_W(HOLDOFF_W)) dut (
    .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid),
    .trig_et(trig_et), .trig_gt(trig_gt), .trig_lt(trig_lt), .trig_run(trig_run),
    .trig_thresh(trig_thresh), .thresh_trig_en(thresh_trig_en), .ext_trig_en(ext_trig_en),
    .chan_mask(chan_mask), .holdoff(holdoff), .arm(arm), .ext_trig_in(ext_trig_in),
    .count_clr(count_clr), .trig_out(trig_out), .trig_src(trig_src),
    .trig_chan(trig_chan), .armed(armed), .trig_count(trig_count)
  );

  typedef struct {
    logic [1:0] src;
    logic [3:0] chan;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   bulk     = 1'b0;
  int   bulk_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_all(logic [DATA_W-1:0] v);
    for (int k = 0; k < N_CHAN; k++) samp[k] = v;
  endtask

  task automatic push_exp(logic [1:0] s, logic [3:0] c, int d);
    sb_q.push_back('{src: s, chan: c, cyc: cyc + d});
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && trig_out) begin
      if (bulk) begin
        bulk_cnt++;
      end else if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_trig: trig_out=1 src=%b chan=%b at cycle %0d, expected no pulse",
                 trig_src, trig_chan, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("trig_src", 32'(trig_src), 32'(mon_e.src));
        check("trig_chan", 32'(trig_chan), 32'(mon_e.chan));
        check("trig_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached with %0d pending pulses", sb_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_all('0);
    tick(2);
    check("rst_trig_out", 32'(trig_out), 0);
    check("rst_trig_src", 32'(trig_src), 0);
    check("rst_trig_chan", 32'(trig_chan), 0);
    check("rst_armed", 32'(armed), 0);
    check("rst_count", 32'(trig_count), 0);
    rst = 1'b0;
    tick(1);

    // Single-shot greater-than crossing on ch2
    trig_thresh = 12'h800; trig_gt = 1'b1; thresh_trig_en = 1'b1;
    chan_mask = 4'hF; holdoff = 16'd3; trig_run = 1'b0;
    adc_valid = 1'b1; samp[2] = 12'h7FF;
    tick(2);
    check("armed_before_arm", 32'(armed), 0);
    pulse_arm();
    check("armed_after_arm", 32'(armed), 1);
    samp[2] = 12'h801;
    push_exp(2'b01, 4'b0100, 1);
    tick(7);
    check("t1_back_idle", 32'(armed), 0);
    check("t1_count", 32'(trig_count), 1);
    check("t1_src_hold", 32'(trig_src), 32'h1);
    check("t1_chan_hold", 32'(trig_chan), 32'h4);

    // Auto-rearm with holdoff 5; the middle crossing lands in holdoff
    set_all(12'h100);
    tick(1);
    holdoff = 16'd5; trig_run = 1'b1;
    tick(1);
    check("t2_armed_by_run", 32'(armed), 1);
    for (int i = 0; i < 24; i++) begin
      if (i == 14) check("t2_in_holdoff", 32'(armed), 0);
      if (i == 18) check("t2_rearmed", 32'(armed), 1);
      samp[0] = (i == 10 || i == 13 || i == 20) ? 12'h900 : 12'h100;
      if (i == 10 || i == 20) push_exp(2'b01, 4'b0001, 1);
      tick(1);
    end
    trig_run = 1'b0;
    tick(8);
    check("t2_idle", 32'(armed), 0);
    check("t2_count", 32'(trig_count), 3);

    // External and threshold events on the same cycle
    holdoff = 16'd2; ext_trig_en = 1'b1;
    pulse_arm();
    ext_trig_in = 1'b1;
    push_exp(2'b11, 4'b0010, 3);
    tick(2);
    samp[1] = 12'h900;
    tick(1);
    samp[1] = 12'h100;
    tick(6);
    ext_trig_in = 1'b0;
    tick(4);
    pulse_arm();
    ext_trig_in = 1'b1;
    push_exp(2'b10, 4'b0000, 3);
    tick(8);
    ext_trig_in = 1'b0;
    tick(4);
    check("t3_count", 32'(trig_count), 5);
    check("t3_idle", 32'(armed), 0);

    // Less-or-equal mode with adc_valid gaps, then masked channel
    trig_gt = 1'b0; trig_lt = 1'b1; trig_et = 1'b1; trig_thresh = 12'h100;
    ext_trig_en = 1'b0; holdoff = 16'd1;
    set_all(12'h900); samp[3] = 12'h200;
    tick(2);
    pulse_arm();
    adc_valid = 1'b0; samp[3] = 12'h100;
    tick(3);
    check("t4_gap_no_fire", 32'(armed), 1);
    adc_valid = 1'b1;
    push_exp(2'b01, 4'b1000, 1);
    tick(5);
    check("t4_count", 32'(trig_count), 6);
    samp[3] = 12'h200;
    tick(2);
    chan_mask = 4'b0111;
    pulse_arm();
    samp[3] = 12'h100;
    tick(4);
    check("t4_masked_no_fire", 32'(armed), 1);

    // Both source enables off: nothing fires
    chan_mask = 4'hF; thresh_trig_en = 1'b0; ext_trig_en = 1'b0;
    samp[3] = 12'h200;
    tick(1);
    samp[3] = 12'h100; ext_trig_in = 1'b1;
    tick(5);
    check("t5_disabled_no_fire", 32'(armed), 1);
    ext_trig_in = 1'b0;
    tick(3);

    // Counter clear and saturation
    count_clr = 1'b1;
    tick(1);
    count_clr = 1'b0;
    check("clr_basic", 32'(trig_count), 0);
    trig_gt = 1'b1; trig_lt = 1'b0; trig_et = 1'b0; trig_thresh = 12'h800;
    thresh_trig_en = 1'b1; chan_mask = 4'b0011; holdoff = 16'd0; trig_run = 1'b1;
    set_all(12'h100);
    tick(2);
    bulk = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      samp[0] = (i % 2 == 0) ? 12'h900 : 12'h100;
      samp[1] = (i % 2 == 0) ? 12'h100 : 12'h900;
      tick(1);
    end
    set_all(12'h100);
    tick(4);
    check("count_at_ffff", 32'(trig_count), 32'hFFFF);
    samp[1] = 12'h900;
    tick(1);
    samp[1] = 12'h100;
    tick(4);
    check("count_saturated", 32'(trig_count), 32'hFFFF);
    bulk = 1'b0;
    check("bulk_pulses", bulk_cnt, 65536);
    count_clr = 1'b1;
    tick(1);
    count_clr = 1'b0;
    check("clr_after_sat", 32'(trig_count), 0);
    samp[0] = 12'h900;
    push_exp(2'b01, 4'b0001, 1);
    tick(1);
    count_clr = 1'b1;
    tick(1);
    count_clr = 1'b0; samp[0] = 12'h100;
    tick(2);
    check("clr_vs_pulse", 32'(trig_count), 0);

    // Reset in holdoff with the external input held high
    trig_run = 1'b0; holdoff = 16'd20; ext_trig_en = 1'b1; thresh_trig_en = 1'b0;
    ext_trig_in = 1'b1;
    push_exp(2'b10, 4'b0000, 3);
    tick(6);
    check("t6_in_holdoff", 32'(armed), 0);
    check("t6_count_pre", 32'(trig_count), 1);
    rst = 1'b1;
    #1;
    check("t6_rst_trig_out", 32'(trig_out), 0);
    check("t6_rst_src", 32'(trig_src), 0);
    check("t6_rst_chan", 32'(trig_chan), 0);
    check("t6_rst_count", 32'(trig_count), 0);
    tick(2);
    rst = 1'b0;
    tick(12);
    check("t6_idle_after_rst", 32'(armed), 0);
    ext_trig_in = 1'b0;
    tick(2);

    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
